// File: rtl/reg_ab_top.sv
// Bus-attached WIDTH-bit register: loads from a shared tri-state bus and drives
// it back on request. Load has priority over output, so the block never drives
// the bus while it is loading from it.
module reg_ab_top #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  inout  tri   [WIDTH-1:0] bus,
  input  logic             ai_n,
  input  logic             ao_n,
  output logic [WIDTH-1:0] A
);

  logic [WIDTH-1:0] reg_q;
  logic             drive_c;

  // Capture the bus exactly as seen; clear is asynchronous and wins over load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      reg_q <= '0;
    end else if (!ai_n) begin
      reg_q <= bus;
    end
  end

  // Output only when not loading: a simultaneous request would self-loop.
  assign drive_c = !ao_n && ai_n;
  assign bus     = drive_c ? reg_q : {WIDTH{1'bz}};
  assign A       = reg_q;

endmodule

// File: tb/tb_reg_ab_top.sv
// Directed vector bench for reg_ab_top: table of bus/register cases plus
// hand-written sequences for asynchronous clear and reset timing.
module tb_reg_ab_top;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         ai_n;
  logic         ao_n;
  logic         drv_en;
  logic [W-1:0] drv_val;
  logic [W-1:0] a_out;
  wire  [W-1:0] bus;

  int tests  = 0;
  int failed = 0;

  assign bus = drv_en ? drv_val : {W{1'bz}};

  reg_ab_top #(.WIDTH(W)) dut (
    .clk  (clk),
    .clr  (clr),
    .bus  (bus),
    .ai_n (ai_n),
    .ao_n (ao_n),
    .A    (a_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic         ai_n;
    logic         ao_n;
    logic         drv_en;
    logic [W-1:0] drv_val;
    logic         chk_bus;
    logic [W-1:0] exp_bus;
    logic [W-1:0] exp_a;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //        clr   ai_n  ao_n  drv   val    chkb  bus    A
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 8'hAA, 8'hAA}; // load 0xAA
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h11, 8'hAA}; // hold, foreign bus data
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'hAA}; // hold
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'hAA}; // hold
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hAA, 8'hAA}; // output onto bus
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C, 8'hAA}; // released: external wins cleanly
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h0F, 8'h0F}; // load priority over nonzero reg
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h0F, 8'h0F}; // output new value
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 8'h00}; // load zero
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 8'hAA, 8'hAA}; // simultaneous, reg was 0
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 8'h00}; // clr beats load
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00}; // drive zero during clr
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 8'hFF}; // first edge after clr loads
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 8'hFF}; // output 0xFF

    // Reset state, before and across the first edge.
    clr = 1'b1; ai_n = 1'b1; ao_n = 1'b1; drv_en = 1'b0; drv_val = '0;
    #2;
    check("reset_a_pre_edge", a_out, 8'h00);
    tick();
    check("reset_a_post_edge", a_out, 8'h00);
    clr = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      clr     = vecs[i].clr;
      ai_n    = vecs[i].ai_n;
      ao_n    = vecs[i].ao_n;
      drv_en  = vecs[i].drv_en;
      drv_val = vecs[i].drv_val;
      #1;
      if (vecs[i].chk_bus) check($sformatf("vec%0d_bus", i), bus, vecs[i].exp_bus);
      tick();
      check($sformatf("vec%0d_a", i), a_out, vecs[i].exp_a);
    end

    // Asynchronous clear between edges after loading 0x55.
    clr = 1'b0; ao_n = 1'b1; ai_n = 1'b0; drv_en = 1'b1; drv_val = 8'h55;
    tick();
    check("clr_seq_load", a_out, 8'h55);
    ai_n = 1'b1; drv_en = 1'b0;
    #2 clr = 1'b1;
    #1 check("clr_seq_async", a_out, 8'h00);
    #1 clr = 1'b0;
    #1 check("clr_seq_released", a_out, 8'h00);
    tick();
    check("clr_seq_hold1", a_out, 8'h00);
    tick();
    check("clr_seq_hold2", a_out, 8'h00);

    // A stays driven with the register value regardless of ao_n.
    ai_n = 1'b0; drv_en = 1'b1; drv_val = 8'hC3;
    tick();
    ai_n = 1'b1; drv_en = 1'b0; ao_n = 1'b0;
    #1 check("a_with_ao_low", a_out, 8'hC3);
    check("bus_with_ao_low", bus, 8'hC3);
    ao_n = 1'b1;
    #1 check("a_with_ao_high", a_out, 8'hC3);
    tick();
    check("a_hold_after_ao", a_out, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reg_ab_top.md
REG_AB_TOP -- requirements
Module: reg_ab_top

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the single clock and clr is the reset.
REQ-002 The block SHALL have parameter WIDTH, default 8, setting the data width of the register and the bus.
REQ-003 Port clk  input  1: rising-edge clock for all state.
REQ-004 Port clr  input  1: asynchronous, active-high clear of the register.
REQ-005 Port bus  inout  WIDTH: shared tri-state system data bus.
REQ-006 Port ai_n  input  1: active-low load enable; bus -> register.
REQ-007 Port ao_n  input  1: active-low output enable; register -> bus.
REQ-008 Port A  output  WIDTH: continuous view of the register contents.

Function
REQ-009 The block SHALL hold one WIDTH-bit register, and A SHALL always equal the register value (no added latency).
REQ-010 On each rising clk edge with clr=0 and ai_n=0, the register SHALL capture the value present on bus; A SHALL update after that edge.
REQ-011 With ai_n=1, the register SHALL hold its value on every clock edge.
REQ-012 With ao_n=0 and ai_n=1, the block SHALL drive bus with the register value, combinationally and in the same cycle.
REQ-013 With ao_n=1, the block SHALL drive all bus bits to high-impedance.
REQ-014 With ai_n=0 and ao_n=0 together, load SHALL take priority: bus SHALL be high-impedance from this block and the register SHALL capture the external bus value (no self-loop, no contention).
REQ-015 The register SHALL capture bus values bit-exactly, including unknown or high-impedance bits; there SHALL be no filtering.
REQ-016 ao_n SHALL NOT affect the register contents; ai_n SHALL affect the bus drive only as specified in REQ-014.
REQ-017 A SHALL remain driven at all times, independent of ao_n.

Reset
REQ-018 clr=1 SHALL force the register and A to all zeros immediately, without waiting for a clock edge.
REQ-019 While clr=1, the register SHALL stay zero regardless of clk and ai_n.
REQ-020 The bus drive SHALL still follow ao_n/ai_n during clr; with ao_n=0 and ai_n=1 it SHALL drive zero.
REQ-021 When clr is released, the first rising edge with ai_n=0 SHALL load normally; there SHALL be no extra recovery cycle.
REQ-022 clr asserted in the same cycle as a load SHALL win, and the register SHALL read zero.

Verification
REQ-023 Scenario clear: load 0x55, then pulse clr=1 between clock edges -> A=0x00 before the next rising edge; A stays 0x00 after clr drops while ai_n=1.
REQ-024 Scenario load: clr=0, external driver puts 0xAA on bus, ai_n=0 across one rising edge, then ai_n=1 -> A=0xAA, held over 3 further edges.
REQ-025 Scenario simultaneous: ai_n=0, ao_n=0, external driver 0xAA, register previously 0x00 -> bus reads 0xAA with no X bits; A=0xAA after the edge.
REQ-026 Scenario output: register=0xAA, ai_n=1, ao_n=0, no external driver -> bus=0xAA in the same cycle.
REQ-027 Scenario release: ao_n=1 -> bus all high-impedance (8'bz) while A still reads 0xAA.
REQ-028 Scenario reset priority: clr=1 with ai_n=0 and bus=0xFF across a rising edge -> A=0x00; after clr=0, the next edge loads 0xFF.
